// File: rtl/serial24to128_arb.sv
// Two-source packet arbiter that packs 24-bit words into 128-bit beats, MSB first.
// Handshake outputs are decoded only from the state registers and never from the inputs.
module serial24to128_arb (
   input  logic         clk,
   input  logic         rst,
   input  logic         s0_valid,
   input  logic [23:0]  s0_data,
   input  logic         s0_last,
   output logic         s0_ready,
   input  logic         s1_valid,
   input  logic [23:0]  s1_data,
   input  logic         s1_last,
   output logic         s1_ready,
   output logic [127:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last,
   output logic         out_src
);

   typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

   state_t        state;
   logic [151:0]  acc;
   logic [7:0]    fcnt;
   logic          owner;
   logic          last_served;

   logic          pack_rdy;
   logic          own_valid;
   logic [23:0]   own_data;
   logic          own_last;
   logic          accept;
   logic          beat;

   always_comb begin
      pack_rdy  = (state == PACK) && (fcnt < 8'd128);
      own_valid = owner ? s1_valid : s0_valid;
      own_data  = owner ? s1_data  : s0_data;
      own_last  = owner ? s1_last  : s0_last;
      s0_ready  = pack_rdy && !owner;
      s1_ready  = pack_rdy && owner;
      out_valid = ((state == PACK) && (fcnt >= 8'd128)) ||
                  ((state == FLUSH) && (fcnt != 8'd0));
      out_last  = (state == FLUSH) && (fcnt <= 8'd128);
      out_data  = acc[151:24];
      out_src   = owner;
      accept    = pack_rdy && own_valid;
      beat      = out_valid && out_ready;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         acc         <= '0;
         fcnt        <= '0;
         owner       <= 1'b0;
         last_served <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (s0_valid || s1_valid) begin
                  owner <= (s0_valid && s1_valid) ? !last_served : s1_valid;
                  state <= PACK;
               end
            end
            PACK: begin
               // Word lands directly below the fcnt bits already held; lower bits stay zero.
               if (accept) begin
                  acc  <= acc | ({own_data, 128'b0} >> fcnt);
                  fcnt <= fcnt + 8'd24;
                  if (own_last)
                     state <= FLUSH;
               end else if (beat) begin
                  acc  <= acc << 128;
                  fcnt <= fcnt - 8'd128;
               end
            end
            FLUSH: begin
               if (beat) begin
                  if (out_last) begin
                     acc         <= '0;
                     fcnt        <= '0;
                     last_served <= owner;
                     state       <= IDLE;
                  end else begin
                     acc  <= acc << 128;
                     fcnt <= fcnt - 8'd128;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
